// File: rtl/stacking_outer_loop_ctrl.sv
// Row-level sequencer for the stacking inner loop: loads each IFM row, publishes
// the valid filter-row window, kicks the inner loop and reports finished output rows.
module stacking_outer_loop_ctrl #(
  parameter int IFM_SIZE_Y          = 8,
  parameter int FILTER_SIZE_Y       = 3,
  parameter int FILTER_SIZE_X       = 3,
  parameter int DIVIDED_CHANNEL_NUM = 32,
  parameter int PREFIX_SUM_SIZE     = 8
) (
  input  logic                                                                clk_i,
  input  logic                                                                rst_i,
  input  logic                                                                layer_start_i,
  input  logic [$clog2(DIVIDED_CHANNEL_NUM+1)-1:0]                            sub_channel_size_i,
  output logic                                                                ifm_row_req_o,
  input  logic                                                                ifm_row_ack_i,
  output logic                                                                inner_loop_start_o,
  input  logic                                                                inner_loop_finish_i,
  output logic [$clog2(IFM_SIZE_Y)-1:0]                                       ifm_loop_y_idx_o,
  output logic [$clog2(IFM_SIZE_Y)-1:0]                                       fil_loop_y_idx_start_o,
  output logic [$clog2(IFM_SIZE_Y)-1:0]                                       fil_loop_y_idx_last_o,
  output logic [$clog2(FILTER_SIZE_X*DIVIDED_CHANNEL_NUM/PREFIX_SUM_SIZE+1)-1:0] fil_loop_y_step_o,
  output logic                                                                out_row_done_o,
  output logic [$clog2(IFM_SIZE_Y-FILTER_SIZE_Y+1)-1:0]                       out_row_idx_o,
  output logic                                                                layer_done_o,
  output logic                                                                busy_o,
  output logic                                                                protocol_err_o
);
  localparam int OUTPUT_SIZE_Y = IFM_SIZE_Y - FILTER_SIZE_Y + 1;
  localparam int Y_W    = $clog2(IFM_SIZE_Y);
  localparam int SC_W   = $clog2(DIVIDED_CHANNEL_NUM+1);
  localparam int STEP_W = $clog2(FILTER_SIZE_X*DIVIDED_CHANNEL_NUM/PREFIX_SUM_SIZE+1);
  localparam int OUT_W  = $clog2(OUTPUT_SIZE_Y);
  localparam int PW     = SC_W + $clog2(FILTER_SIZE_X+1) + $clog2(PREFIX_SUM_SIZE+1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_WAIT, S_DONE} state_t;

  state_t           r_state, w_state_nxt;
  logic [Y_W-1:0]   r_y, w_y_nxt;
  logic             w_y_load;
  logic [Y_W-1:0]   r_fil_start, r_fil_last;
  logic [SC_W-1:0]  r_sc;
  logic             r_row_done;
  logic [OUT_W-1:0] r_row_idx;
  logic             r_perr;
  logic             w_row_fin;
  logic [PW-1:0]    w_step_num;

  // Filter rows that overlap a valid output row for IFM row y
  function automatic logic [Y_W-1:0] f_start(input logic [Y_W-1:0] y);
    if (int'(y) > OUTPUT_SIZE_Y-1) return Y_W'(int'(y) - (OUTPUT_SIZE_Y-1));
    else                           return '0;
  endfunction

  function automatic logic [Y_W-1:0] f_last(input logic [Y_W-1:0] y);
    if (int'(y) < FILTER_SIZE_Y-1) return y;
    else                           return Y_W'(FILTER_SIZE_Y-1);
  endfunction

  assign w_row_fin = (r_state == S_WAIT) && inner_loop_finish_i;

  always_comb begin
    w_state_nxt = r_state;
    w_y_nxt     = r_y;
    w_y_load    = 1'b0;
    case (r_state)
      S_IDLE:  if (layer_start_i) begin
                 w_state_nxt = S_LOAD;
                 w_y_nxt     = '0;
                 w_y_load    = 1'b1;
               end
      S_LOAD:  if (ifm_row_ack_i) w_state_nxt = S_START;
      S_START: w_state_nxt = S_WAIT;
      S_WAIT:  if (inner_loop_finish_i) begin
                 if (int'(r_y) == IFM_SIZE_Y-1) w_state_nxt = S_DONE;
                 else begin
                   w_state_nxt = S_LOAD;
                   w_y_nxt     = r_y + 1'b1;
                   w_y_load    = 1'b1;
                 end
               end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_y         <= '0;
      r_fil_start <= '0;
      r_fil_last  <= '0;
      r_sc        <= '0;
      r_row_done  <= 1'b0;
      r_row_idx   <= '0;
      r_perr      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_row_done <= w_row_fin && (int'(r_y) >= FILTER_SIZE_Y-1);
      if (w_y_load) begin
        r_y         <= w_y_nxt;
        r_fil_start <= f_start(w_y_nxt);
        r_fil_last  <= f_last(w_y_nxt);
      end
      if (r_state == S_IDLE && layer_start_i) r_sc <= sub_channel_size_i;
      if (w_row_fin && int'(r_y) >= FILTER_SIZE_Y-1)
        r_row_idx <= OUT_W'(int'(r_y) - (FILTER_SIZE_Y-1));
      if (inner_loop_finish_i && r_state != S_WAIT) r_perr <= 1'b1;
    end
  end

  // ceil(FILTER_SIZE_X * channels / PREFIX_SUM_SIZE) sparsemap words per filter row
  assign w_step_num = PW'(FILTER_SIZE_X) * PW'(r_sc) + PW'(PREFIX_SUM_SIZE-1);

  assign fil_loop_y_step_o      = STEP_W'(w_step_num / PW'(PREFIX_SUM_SIZE));
  assign ifm_row_req_o          = (r_state == S_LOAD);
  assign inner_loop_start_o     = (r_state == S_START);
  assign layer_done_o           = (r_state == S_DONE);
  assign busy_o                 = (r_state != S_IDLE);
  assign ifm_loop_y_idx_o       = r_y;
  assign fil_loop_y_idx_start_o = r_fil_start;
  assign fil_loop_y_idx_last_o  = r_fil_last;
  assign out_row_done_o         = r_row_done;
  assign out_row_idx_o          = r_row_idx;
  assign protocol_err_o         = r_perr;
endmodule

// File: tb/tb_stacking_outer_loop_ctrl.sv
// Randomized bench for stacking_outer_loop_ctrl: drives layers with varied ack/finish
// timing and checks every row against a row-window / step reference model.
module tb_stacking_outer_loop_ctrl;
  localparam int IFM = 8, FY = 3, FX = 3, DCN = 32, PS = 8, OUTY = IFM - FY + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1, layer_start = 1'b0, ack = 1'b0, fin = 1'b0;
  logic [5:0] sc_i = '0;
  logic       req, st, out_done, ldone, busy, perr;
  logic [2:0] yidx, fstart, flast, oidx;
  logic [3:0] step;

  int  errs = 0, checks = 0;
  int  n_start = 0, n_ldone = 0;
  bit  exp_perr = 1'b0;

  stacking_outer_loop_ctrl #(
    .IFM_SIZE_Y(IFM), .FILTER_SIZE_Y(FY), .FILTER_SIZE_X(FX),
    .DIVIDED_CHANNEL_NUM(DCN), .PREFIX_SUM_SIZE(PS)
  ) dut (
    .clk_i(clk), .rst_i(rst), .layer_start_i(layer_start), .sub_channel_size_i(sc_i),
    .ifm_row_req_o(req), .ifm_row_ack_i(ack), .inner_loop_start_o(st),
    .inner_loop_finish_i(fin), .ifm_loop_y_idx_o(yidx), .fil_loop_y_idx_start_o(fstart),
    .fil_loop_y_idx_last_o(flast), .fil_loop_y_step_o(step), .out_row_done_o(out_done),
    .out_row_idx_o(oidx), .layer_done_o(ldone), .busy_o(busy), .protocol_err_o(perr)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (st)    n_start++;
    if (ldone) n_ldone++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference model: window of filter rows touching a valid output row, and word step
  function automatic int m_start(input int y);
    return (y - (OUTY-1) > 0) ? y - (OUTY-1) : 0;
  endfunction
  function automatic int m_last(input int y);
    return (y < FY-1) ? y : FY-1;
  endfunction
  function automatic int m_step(input int sc);
    return (FX*sc + PS - 1) / PS;
  endfunction

  task automatic tick;
    @(negedge clk);
  endtask

  // ack_dly/fin_dly < 0 -> random per row; rst_row >= 0 -> reset in WAIT of that row
  task automatic run_layer(input int sc, input int ack_dly, input int fin_dly,
                           input bit inj_busy, input bit inj_perr, input int rst_row);
    int a, f, cnt, rc, s0, d0, es;
    s0 = n_start; d0 = n_ldone; es = m_step(sc);
    layer_start = 1'b1; sc_i = 6'(sc);
    tick;
    layer_start = 1'b0; sc_i = 6'($urandom_range(0, 32));
    for (int y = 0; y < IFM; y++) begin
      a = (ack_dly < 0) ? int'($urandom_range(0, 4)) : ack_dly;
      f = (fin_dly < 0) ? int'($urandom_range(1, 6)) : fin_dly;
      cnt = 0;
      while (!req && cnt < 20) begin tick; cnt++; end
      checks++;
      if (req !== 1'b1) begin
        errs++; $display("FAIL req_timeout: row %0d req=%b required 1", y, req);
        return;
      end
      checks++;
      if ({yidx, fstart, flast} !== {3'(y), 3'(m_start(y)), 3'(m_last(y))}) begin
        errs++;
        $display("FAIL row_range: row %0d got y=%0d start=%0d last=%0d required y=%0d start=%0d last=%0d",
                 y, yidx, fstart, flast, y, m_start(y), m_last(y));
      end
      rc = 0;
      for (int d = 0; d < a; d++) begin
        if (inj_perr && y == 1 && d == 0) begin fin = 1'b1; exp_perr = 1'b1; end
        if (req) rc++;
        tick;
        fin = 1'b0;
      end
      ack = 1'b1;
      if (req) rc++;
      tick;
      ack = 1'b0;
      checks++;
      if (rc != a + 1) begin
        errs++; $display("FAIL req_len: row %0d req high %0d cycles required %0d", y, rc, a + 1);
      end
      checks++;
      if ({st, req} !== 2'b10) begin
        errs++; $display("FAIL start_pulse: row %0d start=%b req=%b required start=1 req=0", y, st, req);
      end
      checks++;
      if (step !== 4'(es)) begin
        errs++; $display("FAIL step: row %0d got %0d required %0d", y, step, es);
      end
      tick;
      checks++;
      if ({st, busy} !== 2'b01) begin
        errs++; $display("FAIL start_once: row %0d start=%b busy=%b required 0/1", y, st, busy);
      end
      for (int d = 0; d < f - 1; d++) begin
        if (d == 0) ack = 1'b1;
        if (inj_busy && y == 3 && d == 0) layer_start = 1'b1;
        if (rst_row == y && d == 0) begin
          ack = 1'b0; rst = 1'b1;
          tick;
          rst = 1'b0; exp_perr = 1'b0;
          checks++;
          if ({req, st, yidx, fstart, flast, step, out_done, oidx, ldone, busy, perr} !== '0) begin
            errs++;
            $display("FAIL mid_reset: busy=%b req=%b y=%0d start=%0d last=%0d step=%0d done=%b idx=%0d ldone=%b perr=%b required all 0",
                     busy, req, yidx, fstart, flast, step, out_done, oidx, ldone, perr);
          end
          tick;
          checks++;
          if ({out_done, ldone, busy} !== 3'b000 || n_ldone != d0) begin
            errs++; $display("FAIL reset_no_done: done=%b ldone=%b busy=%b layer_done pulses=%0d required 0",
                             out_done, ldone, busy, n_ldone - d0);
          end
          return;
        end
        tick;
        ack = 1'b0; layer_start = 1'b0;
      end
      fin = 1'b1;
      tick;
      fin = 1'b0;
      checks++;
      if (out_done !== (y >= FY-1)) begin
        errs++; $display("FAIL row_done: row %0d got %b required %b", y, out_done, (y >= FY-1));
      end
      if (y >= FY-1) begin
        checks++;
        if (oidx !== 3'(y - (FY-1))) begin
          errs++; $display("FAIL row_idx: row %0d got %0d required %0d", y, oidx, y - (FY-1));
        end
      end
      checks++;
      if (ldone !== (y == IFM-1)) begin
        errs++; $display("FAIL layer_done: row %0d got %b required %b", y, ldone, (y == IFM-1));
      end
      checks++;
      if (perr !== exp_perr) begin
        errs++; $display("FAIL protocol_err: row %0d got %b required %b", y, perr, exp_perr);
      end
    end
    tick;
    checks++;
    if ({busy, ldone, out_done} !== 3'b000) begin
      errs++; $display("FAIL idle_after: busy=%b ldone=%b done=%b required 0", busy, ldone, out_done);
    end
    checks++;
    if (n_start - s0 != IFM || n_ldone - d0 != 1) begin
      errs++; $display("FAIL pulse_count: starts=%0d layer_done=%0d required %0d and 1",
                       n_start - s0, n_ldone - d0, IFM);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick; tick;
    checks++;
    if ({req, st, yidx, fstart, flast, step, out_done, oidx, ldone, busy, perr} !== '0) begin
      errs++; $display("FAIL reset_state: outputs %h required 0",
                       {req, st, yidx, fstart, flast, step, out_done, oidx, ldone, busy, perr});
    end
    rst = 1'b0;
    tick;
  endtask

  task automatic test_default;
    run_layer(16, 0, 5, 1'b0, 1'b0, -1);
    checks++;
    if (step !== 4'd6) begin errs++; $display("FAIL default_step: got %0d required 6", step); end
  endtask

  task automatic test_step;
    int scs[3] = '{5, 32, 0};
    int exp[3] = '{2, 12, 0};
    for (int i = 0; i < 3; i++) begin
      run_layer(scs[i], 0, 1, 1'b0, 1'b0, -1);
      checks++;
      if (step !== 4'(exp[i])) begin
        errs++; $display("FAIL step_sc%0d: got %0d required %0d", scs[i], step, exp[i]);
      end
    end
  endtask

  task automatic test_ack_delay;
    run_layer(9, 7, 3, 1'b0, 1'b0, -1);
  endtask

  task automatic test_busy_perr;
    run_layer(20, 3, 2, 1'b1, 1'b1, -1);
    tick; tick;
    checks++;
    if (perr !== 1'b1) begin errs++; $display("FAIL perr_sticky: got %b required 1", perr); end
  endtask

  task automatic test_reset_mid;
    run_layer(16, 1, 4, 1'b0, 1'b0, 4);
    run_layer(16, 0, 2, 1'b0, 1'b0, -1);
  endtask

  task automatic test_random;
    repeat (4) run_layer(int'($urandom_range(0, 32)), -1, -1, 1'b0, 1'b0, -1);
  endtask

  initial begin
    test_reset;
    test_default;
    test_step;
    test_ack_delay;
    test_busy_perr;
    test_reset_mid;
    test_random;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
